alu_sequencer: RTL and testbench

Sequential front end for the 32-bit gate-level ALU. Accepts one operation at a time (operands plus 3-bit command) over a valid/ready request channel and drives them onto the ALU inputs. It holds them for a programmable settle window that covers the gate-delay ripple, then captures result and flags and returns them over a valid/ready response channel. It sits between the datapath controller and the ALU, so nothing upstream ever samples unsettled ALU outputs.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_sequencer_settle_timer.sv | 33 +++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: command encodings,
// sequencer FSM states and the response-capture masking rule.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             carry;
        logic             overflow;
        logic             zero;
    } alu_rsp_t;

    // Flags that are meaningless for a command are forced low; zero always
    // reflects the result actually returned, never the ALU's own zero flag.
    function automatic alu_rsp_t mask_result(input alu_cmd_e         cmd,
                                             input logic [ALU_W-1:0] out,
                                             input logic             carry,
                                             input logic             overflow);
        alu_rsp_t r;
        r.result   = out;
        r.carry    = 1'b0;
        r.overflow = 1'b0;
        case (cmd)
            CMD_ADD, CMD_SUB: begin
                r.carry    = carry;
                r.overflow = overflow;
            end
            CMD_SLT: begin
                r.result   = {{(ALU_W-1){1'b0}}, out[0]};
                r.overflow = overflow;
            end
            default: ;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_sequencer_settle_timer.sv
// Down-counter that times the ALU settle window: load, count down to zero, hold.
module settle_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != 8'd0)) begin
            count_next = count_reg - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign done = (count_reg == 8'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front end for the gate-level ALU: registers operands,
// waits out the ripple settle window, then returns masked result and flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    seq_state_e       state_reg,     state_next;
    logic             req_ready_reg, req_ready_next;
    logic             rsp_valid_reg, rsp_valid_next;
    alu_rsp_t         rsp_reg,       rsp_next;
    logic [ALU_W-1:0] alu_a_reg,     alu_a_next;
    logic [ALU_W-1:0] alu_b_reg,     alu_b_next;
    alu_cmd_e         alu_cmd_reg,   alu_cmd_next;
    logic [CNT_W-1:0] ops_done_reg,  ops_done_next;

    logic timer_load;
    logic timer_dec;
    logic timer_done;

    // The ALU's zero flag is ignored: zero is rebuilt from the masked result.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    settle_timer u_settle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    always_comb begin
        state_next    = state_reg;
        rsp_next      = rsp_reg;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_cmd_next  = alu_cmd_reg;
        ops_done_next = ops_done_reg;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    alu_a_next   = req_a;
                    alu_b_next   = req_b;
                    alu_cmd_next = alu_cmd_e'(req_cmd);
                    timer_load   = 1'b1;
                    state_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_done) begin
                    rsp_next   = mask_result(alu_cmd_reg, alu_out, alu_carry, alu_overflow);
                    state_next = RESP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_next = ops_done_reg + CNT_W'(1);
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake flags are registered copies of the upcoming state, so a
        // completed response cannot also accept a request on the same edge.
        req_ready_next = (state_next == IDLE);
        rsp_valid_next = (state_next == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_cmd_reg   <= CMD_ADD;
            ops_done_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_reg       <= rsp_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_cmd_reg   <= alu_cmd_next;
            ops_done_reg  <= ops_done_next;
        end
    end

    assign req_ready    = req_ready_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_result   = rsp_reg.result;
    assign rsp_carry    = rsp_reg.carry;
    assign rsp_overflow = rsp_reg.overflow;
    assign rsp_zero     = rsp_reg.zero;
    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_cmd      = alu_cmd_reg;
    assign busy         = (state_reg != IDLE);
    assign ops_done     = ops_done_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, randomized
// operations against an arithmetic reference, mid-operation reset and counter wrap.
module tb_alu_sequencer;

    localparam int S  = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        int          hold;
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [2:0]    req_cmd;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_carry;
    logic          rsp_overflow;
    logic          rsp_zero;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [2:0]    alu_cmd;
    logic [31:0]   alu_out;
    logic          alu_carry;
    logic          alu_overflow;
    logic          alu_zero;
    logic          busy;
    logic [CW-1:0] ops_done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int age    = 255;
    int exp_ops = 0;
    int last_acc = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cmd      (alu_cmd),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .busy         (busy),
        .ops_done     (ops_done)
    );

    // Architectural result of a command, computed with wide signed arithmetic.
    function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sd;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (cmd)
            3'd0: begin
                u   = {1'b0, a} + {1'b0, b};
                e.r = u[31:0];
                e.c = u[32];
                sd  = sa + sb;
                e.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                sd  = sa - sb;
                e.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            3'd2: e.r = a ^ b;
            3'd3: begin
                e.r = (sa < sb) ? 32'd1 : 32'd0;
                sd  = sa - sb;
                e.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            3'd4: e.r = a & b;
            3'd5: e.r = ~(a & b);
            3'd6: e.r = ~(a | b);
            default: e.r = a | b;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // ALU stand-in: junk in bits/flags that must be masked, and inverted
    // outputs until the operands have been stable for S-1 edges.
    exp_t env;
    always_comb begin
        env = ref_op(alu_a, alu_b, alu_cmd);
        if (alu_cmd == 3'd3) env.r[31:1] = alu_a[31:1] ^ ~alu_b[31:1];
        if (alu_cmd > 3'd1) env.c = 1'b1;
        if (alu_cmd > 3'd1 && alu_cmd != 3'd3) env.o = 1'b1;
        env.z = ~env.z;
        if (age < S - 1) begin
            env.r = ~env.r;
            env.c = ~env.c;
            env.o = ~env.o;
        end
    end
    assign alu_out      = env.r;
    assign alu_carry    = env.c;
    assign alu_overflow = env.o;
    assign alu_zero     = env.z;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) age <= 0;
        else if (age < 255) age <= age + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] cmd, input int hold,
                          input logic [31:0] er, input logic ec, input logic eo, input logic ez);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({name, " ready"}, {31'd0, req_ready}, 32'd1);
        req_a = a; req_b = b; req_cmd = cmd; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(negedge clk);
        last_acc = cyc;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_cmd = 3'($urandom);
        chk({name, " alu_a"}, alu_a, a);
        chk({name, " alu_b"}, alu_b, b);
        chk({name, " alu_cmd"}, {29'd0, alu_cmd}, {29'd0, cmd});
        chk({name, " busy/ready"}, {30'd0, busy, req_ready}, 32'd2);
        lat = 0;
        while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
        chk({name, " latency"}, lat, S);
        chk({name, " result"}, rsp_result, er);
        chk({name, " flags c/o/z"}, {29'd0, rsp_carry, rsp_overflow, rsp_zero}, {29'd0, ec, eo, ez});
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_a = ~a; req_b = ~b; req_cmd = cmd + 3'd1;
            @(negedge clk);
            chk({name, " hold rsp"}, {rsp_valid, req_ready, busy, rsp_carry, rsp_overflow, rsp_zero, 26'd0},
                {1'b1, 1'b0, 1'b1, ec, eo, ez, 26'd0});
            chk({name, " hold result"}, rsp_result, er);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_ops = (exp_ops + 1) % (1 << CW);
        chk({name, " post valid/ready/busy"}, {29'd0, rsp_valid, req_ready, busy}, 32'd2);
        chk({name, " ops_done"}, {{(32-CW){1'b0}}, ops_done}, 32'(exp_ops));
        chk({name, " alu_a kept"}, alu_a, a);
        $display("op %-10s cmd=%0d a=%h b=%h -> r=%h c=%b o=%b z=%b ops=%0d",
                 name, cmd, a, b, rsp_result, rsp_carry, rsp_overflow, rsp_zero, ops_done);
    endtask

    vec_t vecs [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rc;

        vecs[0]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 3'd0, 0,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h80000000, 32'h00000001, 3'd1, 10, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000001, 32'h00000001, 3'd2, 0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000002, 32'h00000001, 3'd3, 0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000001, 32'h00000002, 3'd3, 0,  32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'd0, 1,  32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h80000000, 32'h00000001, 3'd3, 0,  32'h00000001, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h00000000, 32'h00000000, 3'd6, 2,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h000000F0, 32'h00000F00, 3'd7, 0,  32'h00000FF0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h0000F0F0, 32'h0000FF00, 3'd4, 0,  32'h0000F000, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cmd = '0;
        #1;
        chk("reset outputs", {28'd0, req_ready, rsp_valid, busy, rsp_zero}, 32'd0);
        chk("reset ops_done", {{(32-CW){1'b0}}, ops_done}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready before edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready after edge", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].hold,
                   vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = 3'($urandom);
            if (i % 5 == 0) rb = ra;
            e = ref_op(ra, rb, rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 2)), e.r, e.c, e.o, e.z);
        end

        // Abandon an AND mid-settle.
        req_a = 32'hFFFF0000; req_b = 32'h0F0F0F0F; req_cmd = 3'd4; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset ctl", {27'd0, req_ready, rsp_valid, busy, rsp_carry, rsp_overflow}, 32'd0);
        chk("async reset alu_a", alu_a, 32'd0);
        chk("async reset alu_b", alu_b, 32'd0);
        chk("async reset cmd/zero", {29'd0, alu_cmd}, {31'd0, rsp_zero});
        chk("async reset result", rsp_result, 32'd0);
        chk("async reset ops_done", {{(32-CW){1'b0}}, ops_done}, 32'd0);
        repeat (6) @(negedge clk);
        chk("no rsp in reset", {31'd0, rsp_valid}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready low at release", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready after release", {30'd0, req_ready, rsp_valid}, 32'd2);
        $display("reset mid-op: ready=%b valid=%b ops=%0d", req_ready, rsp_valid, ops_done);
        exp_ops = 0;

        // Back-to-back ADDs past the counter wrap, checking best-case spacing.
        prev = 0;
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            ra = $urandom; rb = $urandom;
            e = ref_op(ra, rb, 3'd0);
            run_op($sformatf("b2b%0d", i), ra, rb, 3'd0, 0, e.r, e.c, e.o, e.z);
            if (i > 0) chk("b2b spacing", last_acc - prev, S + 2);
            prev = last_acc;
        end
        chk("ops_done wrap", {{(32-CW){1'b0}}, ops_done}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
